// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants,
// frame configuration record and small bit-level helpers.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } uart_cfg_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one registered tick every max(div,1) clocks,
// restarted by clr. Shared between the RX and TX paths.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] last_s;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;

  // Terminal count and next counter value; a zero divisor behaves as one.
  always_comb begin
    last_s = {DIV_W{1'b0}};
    if (div == {DIV_W{1'b0}}) begin
      last_s = {DIV_W{1'b0}};
    end else begin
      last_s = div - DIV_W'(1);
    end
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else if (cnt_r >= last_s) begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + DIV_W'(1);
    end
  end

  // Tick is registered one cycle ahead so it lines up with the terminal count.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_r <= {DIV_W{1'b0}};
      tick  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      tick  <= (cnt_nxt_s == last_s);
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampled start detection, majority-vote
// bit recovery, parity/stop/break checking and one-cycle character strobe.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             rx_en_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [1:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  input  logic             urxd_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             break_o,
  output logic             busy_o
);

  localparam logic [3:0] SMP_FIRST = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] SMP_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0] SMP_LAST  = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] SMP_END   = 4'(OVERSAMPLE - 1);

  logic             sync1_r;
  logic             sync_r;
  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  uart_cfg_t        cfg_r;
  uart_cfg_t        cfg_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_s;
  logic             clr_s;
  logic             tick_s;
  logic [3:0]       smp_cnt_r;
  logic             smp7_r;
  logic             smp8_r;
  logic             maj_s;
  logic             decide_s;
  logic [2:0]       bit_cnt_r;
  logic             stop_cnt_r;
  logic [7:0]       shreg_r;
  logic             perr_acc_r;
  logic             ferr_acc_r;
  logic             zero_r;
  logic             last_data_s;
  logic             last_stop_s;
  logic             frame_done_s;
  logic [1:0]       shift_s;

  // Two-flop synchronizer; idles at the line's mark level.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1_r <= 1'b1;
      sync_r  <= 1'b1;
    end else begin
      sync1_r <= urxd_i;
      sync_r  <= sync1_r;
    end
  end

  // While idle the live divisor feeds the tick counter so the first tick is
  // timed from the detection edge; afterwards the latched copy is used.
  always_comb begin
    cfg_s        = '{data_bits: data_bits_i, parity_en: parity_en_i,
                     parity_odd: parity_odd_i, stop2: stop2_i};
    clr_s        = (state_r == RX_IDLE);
    div_s        = clr_s ? baud_div_i : div_r;
    maj_s        = majority3(smp7_r, smp8_r, sync_r);
    decide_s     = tick_s && (smp_cnt_r == SMP_LAST);
    last_data_s  = (bit_cnt_r == (3'd4 + {1'b0, cfg_r.data_bits}));
    last_stop_s  = !cfg_r.stop2 || stop_cnt_r;
    frame_done_s = rx_en_i && (state_r == RX_STOP) && decide_s && last_stop_s;
    shift_s      = 2'd3 - cfg_r.data_bits;
  end

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst_ (rst_),
    .clr  (clr_s),
    .div  (div_s),
    .tick (tick_s)
  );

  // Next-state logic; each state hands over at its own bit decision.
  always_comb begin
    state_nxt_s = state_r;
    if (!rx_en_i) begin
      state_nxt_s = RX_IDLE;
    end else begin
      case (state_r)
        RX_IDLE: begin
          if (!sync_r) state_nxt_s = RX_START;
          else         state_nxt_s = RX_IDLE;
        end
        RX_START: begin
          if (decide_s) state_nxt_s = maj_s ? RX_IDLE : RX_DATA;
          else          state_nxt_s = RX_START;
        end
        RX_DATA: begin
          if (decide_s && last_data_s) state_nxt_s = cfg_r.parity_en ? RX_PARITY : RX_STOP;
          else                         state_nxt_s = RX_DATA;
        end
        RX_PARITY: begin
          if (decide_s) state_nxt_s = RX_STOP;
          else          state_nxt_s = RX_PARITY;
        end
        RX_STOP: begin
          if (decide_s && last_stop_s) state_nxt_s = maj_s ? RX_IDLE : RX_WAIT_HIGH;
          else                         state_nxt_s = RX_STOP;
        end
        RX_WAIT_HIGH: begin
          if (sync_r) state_nxt_s = RX_IDLE;
          else        state_nxt_s = RX_WAIT_HIGH;
        end
        default: state_nxt_s = RX_IDLE;
      endcase
    end
  end

  // State register with busy derived from the state being entered.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r <= RX_IDLE;
      busy_o  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_o  <= (state_nxt_s != RX_IDLE) && (state_nxt_s != RX_WAIT_HIGH);
    end
  end

  // Frame datapath: config capture, sample counter, votes and accumulators.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cfg_r      <= '0;
      div_r      <= {DIV_W{1'b0}};
      smp_cnt_r  <= 4'd0;
      smp7_r     <= 1'b1;
      smp8_r     <= 1'b1;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shreg_r    <= 8'd0;
      perr_acc_r <= 1'b0;
      ferr_acc_r <= 1'b0;
      zero_r     <= 1'b1;
    end else if (state_r == RX_IDLE) begin
      smp_cnt_r  <= 4'd0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shreg_r    <= 8'd0;
      perr_acc_r <= 1'b0;
      ferr_acc_r <= 1'b0;
      zero_r     <= 1'b1;
      if (state_nxt_s == RX_START) begin
        cfg_r <= cfg_s;
        div_r <= baud_div_i;
      end
    end else if (tick_s) begin
      smp_cnt_r <= (smp_cnt_r == SMP_END) ? 4'd0 : smp_cnt_r + 4'd1;
      if (smp_cnt_r == SMP_FIRST) smp7_r <= sync_r;
      if (smp_cnt_r == SMP_MID)   smp8_r <= sync_r;
      if (smp_cnt_r == SMP_LAST) begin
        case (state_r)
          RX_DATA: begin
            shreg_r   <= {maj_s, shreg_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            zero_r    <= zero_r & ~maj_s;
          end
          RX_PARITY: begin
            perr_acc_r <= (parity8(shreg_r) ^ maj_s) != cfg_r.parity_odd;
            zero_r     <= zero_r & ~maj_s;
          end
          RX_STOP: begin
            stop_cnt_r <= 1'b1;
            ferr_acc_r <= ferr_acc_r | ~maj_s;
            zero_r     <= zero_r & ~maj_s;
          end
          default: begin
            zero_r <= zero_r;
          end
        endcase
      end
    end
  end

  // Character strobe; data and flags hold until the next completed frame.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_valid_o   <= 1'b0;
      rx_data_o    <= 8'd0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      rx_valid_o <= frame_done_s;
      if (frame_done_s) begin
        rx_data_o    <= shreg_r >> shift_s;
        parity_err_o <= perr_acc_r;
        frame_err_o  <= ferr_acc_r | ~maj_s;
        break_o      <= zero_r & ~maj_s;
      end
    end
  end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Receive-side deserializer for the APB UART. Samples the asynchronous serial input `urxd_i` at 16x the bit rate, detects start bits, recovers 5–8 data bits, checks parity and stop bits, and presents each character with a one-cycle valid pulse. Its output feeds the UART receive FIFO; the APB register block supplies its configuration.

## Interface
Parameters
- `DIV_W`, 16: width of the baud divisor.

Ports
- `clk`, in, 1: single clock, rising edge.
- `rst_`, in, 1: reset, asynchronous and active-low.
- `rx_en_i`, in, 1: receiver enable.
- `baud_div_i`, in, DIV_W: clocks per 1/16 bit. Value 0 is treated as 1.
- `data_bits_i`, in, 2: character length; 0..3 selects 5..8 bits.
- `parity_en_i`, in, 1: a parity bit follows the data bits.
- `parity_odd_i`, in, 1: 1 selects odd parity, 0 selects even.
- `stop2_i`, in, 1: two stop bits.
- `urxd_i`, in, 1: asynchronous serial line; idles high.
- `rx_data_o`, out, 8: received character, LSB-aligned; unused upper bits are 0.
- `rx_valid_o`, out, 1: one-cycle pulse when a character is complete.
- `parity_err_o`, out, 1: parity error flag, qualified by `rx_valid_o`.
- `frame_err_o`, out, 1: framing error flag, qualified by `rx_valid_o`.
- `break_o`, out, 1: break detected, qualified by `rx_valid_o`.
- `busy_o`, out, 1: high while a frame is in progress (any state other than IDLE or WAIT_HIGH).

## Operation
- **Input synchronizer.** `urxd_i` passes through a 2-flop synchronizer whose flops reset to 1. Only the synchronized value is used internally.
- **Tick generator.** A counter produces one tick every max(`baud_div_i`,1) clocks. The divisor, `data_bits_i`, the parity controls and `stop2_i` are latched at start detection and held for the whole frame.
- **Sample counter.** A 4-bit sample counter advances on each tick. The sync line is sampled at counts 7, 8 and 9. The bit value is the majority of those three samples and is decided at count 9. The bit ends at count 15.
- **States** (held in a shared enum): IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on sync line = 0 with `rx_en_i` = 1, go to START. The tick counter and sample counter clear.
  - START: at the decision, a majority of 1 is a false start, so return to IDLE with no output. A majority of 0 goes to DATA.
  - DATA: receive `data_bits_i`+5 bits, LSB first, into a shift register. Then go to PARITY if `parity_en_i` is set, else STOP.
  - PARITY: compute the XOR of the data bits and the parity bit. A parity error is flagged if that XOR ≠ `parity_odd_i`.
  - STOP: decide one stop bit, or two if `stop2_i` is set. A frame error is flagged if any stop bit majority is 0.
    - At the decision of the last stop bit, register `rx_valid_o` = 1 for one clock, together with the data and flags.
    - Go to IDLE if the stop bit was 1, else go to WAIT_HIGH. The state does not wait for the end of the stop bit.
  - WAIT_HIGH: stay until the sync line = 1, then go to IDLE.
- **Break.** Break is flagged when all data bits, the parity bit (if enabled) and every stop bit are 0. `break_o` = 1, `frame_err_o` = 1 and `rx_data_o` = 0.
- **Output holding.** `rx_data_o` and the three flags hold their values until the next `rx_valid_o`.
- **Disable.** When `rx_en_i` = 0 in any state, the block goes to IDLE on the next clock. Any partial frame is discarded and `rx_valid_o` is not pulsed.
- **Reset values.** All outputs reset to 0. The state resets to IDLE. Reset in the middle of a frame aborts it with no output.

## Timing
- The synchronizer adds 2 clocks: a fall on `urxd_i` that is stable before edge 1 is seen in IDLE at edge 2.
- Tick k of bit b (start bit b = 0) occurs at detection + `baud_div_i`·(16b + k + 1) clocks.
- With `baud_div_i` = 1 and an 8N1 frame, `rx_valid_o` is high in clock 157 after the falling edge of `urxd_i` (clock 0). Valid fires 6 ticks before the nominal end of the stop bit.
- `rx_valid_o` is never high for two consecutive clocks.
- The minimum spacing between valid pulses is one full frame.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_e` enum;
  - the constants `OVERSAMPLE` = 16 and `SAMPLE_MID` = 8;
  - the `uart_cfg_t` struct (`data_bits`, `parity_en`, `parity_odd`, `stop2`), shared with the APB register block.
- Sub-module `uart_baud_tick` contains the divisor counter. Its inputs are clk, `rst_`, `clr`, div. Its output is a single `tick`. The same module is reused by the TX side.

## Test plan
- **8N1, 0x5A.** Config `baud_div_i` = 1, 8N1; send 0x5A. Expect one `rx_valid_o` at clock 157, `rx_data_o` = 0x5A, all error flags 0.
- **7E2, 0x41 with wrong parity.** Config 7 data bits, even parity, two stop bits, `baud_div_i` = 4; send 0x41 with parity bit 1. Expect `parity_err_o` = 1, `rx_data_o` = 0x41, `frame_err_o` = 0.
- **Glitch rejection.** Hold the line low for 5 ticks only, then high. Expect no `rx_valid_o`, `busy_o` back to 0, and state IDLE.
- **Break.** Hold the line low for 2 frame times, then high. Expect exactly one valid with `break_o` = 1, `frame_err_o` = 1, data 0x00. Expect no second valid until the line rises and a new start bit arrives.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap. Expect two valids 160 clocks apart with correct data.
- **Abort mid-frame.** Deassert `rx_en_i` during data bit 3, and separately pulse `rst_` during data bit 3. In both cases expect no valid, all outputs 0, and the next frame (0xA5) received cleanly.
